// File: rtl/interrupt_control_fsm_if.sv
// rtl/interrupt_control_fsm_if.sv - request/acknowledge bundle between bus logic and the INTA/poll sequencer
interface interrupt_control_fsm_if #(
  parameter int IRQ_WIDTH = 8
);
  logic                 write_icw1;
  logic                 mode_8086;
  logic [IRQ_WIDTH-1:0] interrupt;
  logic                 inta_end;
  logic                 poll_command;
  logic                 read_end;
  logic                 interrupt_to_cpu;
  logic                 freeze;
  logic                 latch_in_service;
  logic [IRQ_WIDTH-1:0] clear_interrupt_request;
  logic [IRQ_WIDTH-1:0] acknowledge_interrupt;
  logic                 spurious;
  logic                 end_of_acknowledge;
  logic                 end_of_poll;
  logic [1:0]           control_state;

  modport master (
    output write_icw1, mode_8086, interrupt, inta_end, poll_command, read_end,
    input  interrupt_to_cpu, freeze, latch_in_service, clear_interrupt_request,
           acknowledge_interrupt, spurious, end_of_acknowledge, end_of_poll, control_state
  );

  modport slave (
    input  write_icw1, mode_8086, interrupt, inta_end, poll_command, read_end,
    output interrupt_to_cpu, freeze, latch_in_service, clear_interrupt_request,
           acknowledge_interrupt, spurious, end_of_acknowledge, end_of_poll, control_state
  );
endinterface

// File: rtl/interrupt_control_fsm.sv
// rtl/interrupt_control_fsm.sv - INT raise, INTA sequence (8080/8086) and poll read sequencer
module interrupt_control_fsm #(
  parameter int IRQ_WIDTH = 8
) (
  input logic                    clock,
  input logic                    reset,
  interrupt_control_fsm_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_ACK2 = 2'b01,
    WAIT_ACK3 = 2'b10,
    POLL      = 2'b11
  } state_t;

  // Vector reported when an acknowledge finds nothing pending.
  localparam logic [IRQ_WIDTH-1:0] SPURIOUS_VEC = {1'b1, {(IRQ_WIDTH-1){1'b0}}};

  state_t               state, state_next;
  logic                 int_q, int_next;
  logic                 freeze_q, freeze_next;
  logic                 latch_q, latch_next;
  logic [IRQ_WIDTH-1:0] clear_q, clear_next;
  logic [IRQ_WIDTH-1:0] ack_q, ack_next;
  logic                 spur_q, spur_next;
  logic                 eoa_q, eoa_next;
  logic                 eop_q, eop_next;
  logic [IRQ_WIDTH-1:0] lowest;
  logic                 any_req;

  // Two's-complement trick isolates the lowest set bit of a possibly multi-hot request.
  assign lowest  = bus.interrupt & (-bus.interrupt);
  assign any_req = |bus.interrupt;

  // Next state and next registered outputs; ICW1 outranks every sequence event.
  always_comb begin
    state_next  = state;
    int_next    = int_q;
    latch_next  = 1'b0;
    clear_next  = '0;
    ack_next    = ack_q;
    spur_next   = spur_q;
    eoa_next    = 1'b0;
    eop_next    = 1'b0;
    if (bus.write_icw1) begin
      state_next = IDLE;
      int_next   = 1'b0;
      ack_next   = '0;
      spur_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inta_end) begin
            int_next   = 1'b0;
            state_next = WAIT_ACK2;
            if (any_req) begin
              ack_next   = lowest;
              clear_next = lowest;
              latch_next = 1'b1;
              spur_next  = 1'b0;
            end else begin
              ack_next  = SPURIOUS_VEC;
              spur_next = 1'b1;
            end
          end else if (bus.poll_command) begin
            int_next   = 1'b0;
            state_next = POLL;
          end else begin
            int_next = any_req;
          end
        end
        WAIT_ACK2: begin
          int_next = 1'b0;
          if (bus.inta_end) begin
            if (bus.mode_8086) begin
              eoa_next   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_ACK3;
            end
          end
        end
        WAIT_ACK3: begin
          int_next = 1'b0;
          if (bus.inta_end) begin
            eoa_next   = 1'b1;
            state_next = IDLE;
          end
        end
        POLL: begin
          int_next = 1'b0;
          if (bus.read_end) begin
            // Poll reports the raw capture: no spurious substitution.
            ack_next   = lowest;
            clear_next = lowest;
            latch_next = any_req;
            spur_next  = 1'b0;
            eop_next   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    freeze_next = (state_next != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      int_q    <= 1'b0;
      freeze_q <= 1'b0;
      latch_q  <= 1'b0;
      clear_q  <= '0;
      ack_q    <= '0;
      spur_q   <= 1'b0;
      eoa_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state    <= state_next;
      int_q    <= int_next;
      freeze_q <= freeze_next;
      latch_q  <= latch_next;
      clear_q  <= clear_next;
      ack_q    <= ack_next;
      spur_q   <= spur_next;
      eoa_q    <= eoa_next;
      eop_q    <= eop_next;
    end
  end

  assign bus.interrupt_to_cpu        = int_q;
  assign bus.freeze                  = freeze_q;
  assign bus.latch_in_service        = latch_q;
  assign bus.clear_interrupt_request = clear_q;
  assign bus.acknowledge_interrupt   = ack_q;
  assign bus.spurious                = spur_q;
  assign bus.end_of_acknowledge      = eoa_q;
  assign bus.end_of_poll             = eop_q;
  assign bus.control_state           = state;
endmodule

// File: tb/tb_interrupt_control_fsm.sv
// tb/tb_interrupt_control_fsm.sv - randomized and directed check of the sequencer at widths 8 and 16
module tb_interrupt_control_fsm;
  logic clock = 1'b0;
  logic reset = 1'b1;

  interrupt_control_fsm_if #(.IRQ_WIDTH(8))  if8 ();
  interrupt_control_fsm_if #(.IRQ_WIDTH(16)) if16 ();

  interrupt_control_fsm #(.IRQ_WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(if8));
  interrupt_control_fsm #(.IRQ_WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(if16));

  always #5 clock = ~clock;

  logic        write_icw1, mode_8086, inta_end, poll_command, read_end;
  logic [7:0]  irq8;
  logic [15:0] irq16;

  assign if8.write_icw1    = write_icw1;
  assign if8.mode_8086     = mode_8086;
  assign if8.inta_end      = inta_end;
  assign if8.poll_command  = poll_command;
  assign if8.read_end      = read_end;
  assign if8.interrupt     = irq8;
  assign if16.write_icw1   = write_icw1;
  assign if16.mode_8086    = mode_8086;
  assign if16.inta_end     = inta_end;
  assign if16.poll_command = poll_command;
  assign if16.read_end     = read_end;
  assign if16.interrupt    = irq16;

  int checks = 0;
  int failures = 0;

  // Reference model: INTA count seen in the current sequence plus a polling flag.
  int          m_acks [2];
  bit          m_poll [2];
  bit          m_int [2], m_latch [2], m_spur [2], m_eoa [2], m_eop [2];
  logic [15:0] m_clear [2], m_ack [2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_state(input int k);
    if (m_poll[k]) return 2'd3;
    return 2'(m_acks[k]);
  endfunction

  task automatic model_step(input int k, input int w, input logic [15:0] x);
    logic [15:0] lsb;
    lsb = x & (~x + 16'd1);
    m_latch[k] = 0; m_clear[k] = '0; m_eoa[k] = 0; m_eop[k] = 0;
    if (reset || write_icw1) begin
      m_acks[k] = 0; m_poll[k] = 0; m_int[k] = 0; m_ack[k] = '0; m_spur[k] = 0;
    end else if (m_poll[k]) begin
      if (read_end) begin
        m_ack[k] = lsb; m_clear[k] = lsb; m_latch[k] = (x != 0); m_spur[k] = 0;
        m_eop[k] = 1; m_poll[k] = 0;
      end
    end else if (m_acks[k] == 0) begin
      if (inta_end) begin
        m_int[k] = 0; m_acks[k] = 1;
        if (x != 0) begin
          m_ack[k] = lsb; m_clear[k] = lsb; m_latch[k] = 1; m_spur[k] = 0;
        end else begin
          m_ack[k] = 16'd1 << (w - 1); m_spur[k] = 1;
        end
      end else if (poll_command) begin
        m_int[k] = 0; m_poll[k] = 1;
      end else begin
        m_int[k] = (x != 0);
      end
    end else if (inta_end) begin
      if (m_acks[k] == 2 || mode_8086) begin
        m_eoa[k] = 1; m_acks[k] = 0;
      end else begin
        m_acks[k] = 2;
      end
    end
  endtask

  task automatic compare_inst(input int k, input logic [1:0] st, input logic it, input logic fr,
                              input logic la, input logic [15:0] cl, input logic [15:0] ak,
                              input logic sp, input logic ea, input logic ep);
    string p;
    p = (k == 0) ? "w8" : "w16";
    check({p, " state"}, {14'd0, st}, {14'd0, m_state(k)});
    check({p, " int"}, {15'd0, it}, {15'd0, m_int[k]});
    check({p, " freeze"}, {15'd0, fr}, {15'd0, m_acks[k] != 0 || m_poll[k]});
    check({p, " latch"}, {15'd0, la}, {15'd0, m_latch[k]});
    check({p, " clear"}, cl, m_clear[k]);
    check({p, " ack"}, ak, m_ack[k]);
    check({p, " spurious"}, {15'd0, sp}, {15'd0, m_spur[k]});
    check({p, " eoa"}, {15'd0, ea}, {15'd0, m_eoa[k]});
    check({p, " eop"}, {15'd0, ep}, {15'd0, m_eop[k]});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(0, 8, {8'd0, irq8});
    model_step(1, 16, irq16);
    #1;
    compare_inst(0, if8.control_state, if8.interrupt_to_cpu, if8.freeze, if8.latch_in_service,
                 {8'd0, if8.clear_interrupt_request}, {8'd0, if8.acknowledge_interrupt},
                 if8.spurious, if8.end_of_acknowledge, if8.end_of_poll);
    compare_inst(1, if16.control_state, if16.interrupt_to_cpu, if16.freeze, if16.latch_in_service,
                 if16.clear_interrupt_request, if16.acknowledge_interrupt,
                 if16.spurious, if16.end_of_acknowledge, if16.end_of_poll);
  endtask

  task automatic inta();
    inta_end = 1; cycle(); inta_end = 0;
  endtask

  initial begin
    write_icw1 = 0; mode_8086 = 1; inta_end = 0; poll_command = 0; read_end = 0;
    irq8 = 8'h00; irq16 = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      m_acks[k] = 0; m_poll[k] = 0; m_int[k] = 0; m_latch[k] = 0; m_spur[k] = 0;
      m_eoa[k] = 0; m_eop[k] = 0; m_clear[k] = '0; m_ack[k] = '0;
    end
    reset = 1; irq8 = 8'hFF;
    cycle(); cycle();
    check("reset state", {14'd0, if8.control_state}, 16'd0);
    check("reset int", {15'd0, if8.interrupt_to_cpu}, 16'd0);
    reset = 0; irq8 = 8'h00;
    cycle();

    // 8086 sequence, plus 16-bit top line
    mode_8086 = 1; irq8 = 8'h02; irq16 = 16'h8000;
    cycle();
    check("8086 int raised", {15'd0, if8.interrupt_to_cpu}, 16'd1);
    inta();
    check("8086 ack", {8'd0, if8.acknowledge_interrupt}, 16'h0002);
    check("8086 clear", {8'd0, if8.clear_interrupt_request}, 16'h0002);
    check("8086 latch", {15'd0, if8.latch_in_service}, 16'd1);
    check("8086 state", {14'd0, if8.control_state}, 16'd1);
    check("w16 ack", if16.acknowledge_interrupt, 16'h8000);
    check("w16 spurious", {15'd0, if16.spurious}, 16'd0);
    cycle();
    check("8086 latch width", {15'd0, if8.latch_in_service}, 16'd0);
    inta();
    check("8086 eoa", {15'd0, if8.end_of_acknowledge}, 16'd1);
    check("8086 freeze off", {15'd0, if8.freeze}, 16'd0);

    // 8080 sequence
    mode_8086 = 0; irq8 = 8'h80;
    cycle();
    inta();
    check("8080 s1", {14'd0, if8.control_state}, 16'd1);
    inta();
    check("8080 s2", {14'd0, if8.control_state}, 16'd2);
    check("8080 no early eoa", {15'd0, if8.end_of_acknowledge}, 16'd0);
    inta();
    check("8080 s3", {14'd0, if8.control_state}, 16'd0);
    check("8080 eoa", {15'd0, if8.end_of_acknowledge}, 16'd1);

    // spurious
    irq8 = 8'h10; irq16 = 16'h0000;
    cycle();
    irq8 = 8'h00;
    inta();
    check("spur ack", {8'd0, if8.acknowledge_interrupt}, 16'h0080);
    check("spur flag", {15'd0, if8.spurious}, 16'd1);
    check("spur latch", {15'd0, if8.latch_in_service}, 16'd0);
    check("spur clear", {8'd0, if8.clear_interrupt_request}, 16'd0);
    inta(); inta();

    // poll
    irq8 = 8'h24; poll_command = 1;
    cycle();
    poll_command = 0;
    check("poll state", {14'd0, if8.control_state}, 16'd3);
    check("poll freeze", {15'd0, if8.freeze}, 16'd1);
    check("poll int", {15'd0, if8.interrupt_to_cpu}, 16'd0);
    read_end = 1;
    cycle();
    read_end = 0;
    check("poll ack", {8'd0, if8.acknowledge_interrupt}, 16'h0004);
    check("poll latch", {15'd0, if8.latch_in_service}, 16'd1);
    check("poll eop", {15'd0, if8.end_of_poll}, 16'd1);
    check("poll idle", {14'd0, if8.control_state}, 16'd0);

    // ICW1 abort in WAIT_ACK2
    mode_8086 = 0; irq8 = 8'h01;
    cycle();
    inta();
    write_icw1 = 1; irq8 = 8'hFF; inta_end = 1;
    cycle();
    write_icw1 = 0; inta_end = 0;
    check("icw1 state", {14'd0, if8.control_state}, 16'd0);
    check("icw1 int", {15'd0, if8.interrupt_to_cpu}, 16'd0);
    check("icw1 ack", {8'd0, if8.acknowledge_interrupt}, 16'd0);
    check("icw1 eoa", {15'd0, if8.end_of_acknowledge}, 16'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      write_icw1   = ($urandom_range(0, 39) == 0);
      mode_8086    = 1'($urandom_range(0, 1));
      inta_end     = ($urandom_range(0, 3) == 0);
      poll_command = ($urandom_range(0, 7) == 0);
      read_end     = ($urandom_range(0, 3) == 0);
      irq8         = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      irq16        = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
